// File: rtl/lcg_mac_sequencer_pkg.sv
// Shared types and constants for the shift-add LCG step sequencer.
package lcg_mac_sequencer_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam int unsigned DefaultWidth = 64;

  // MMIX (Knuth) LCG constants
  localparam logic [63:0] MmixA = 64'd6364136223846793005;
  localparam logic [63:0] MmixC = 64'd1442695040888963407;

  // Two multiplier bits retire per iteration
  function automatic int unsigned iter_of(input int unsigned width);
    return width / 2;
  endfunction

endpackage

// File: rtl/lcg_mac_sequencer_csa3_adder.sv
// Three-operand carry-save adder with a final carry-propagate stage; purely combinational.
module csa3_adder #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic             cin_i,
  output logic [WIDTH:0]   sum_o,
  output logic             cout_o
);

  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH-1:0] carry_bits;
  logic [WIDTH+1:0] total;

  assign sum_bits   = a_i ^ b_i ^ c_i;
  assign carry_bits = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

  assign total  = {2'b00, sum_bits} + {1'b0, carry_bits, 1'b0} + {{(WIDTH + 1){1'b0}}, cin_i};
  assign sum_o  = total[WIDTH:0];
  assign cout_o = total[WIDTH+1];

endmodule

// File: rtl/lcg_mac_sequencer.sv
// Computes x_next = A*x + C mod 2^WIDTH by radix-4 shift-add through one shared CSA adder.
module lcg_mac_sequencer
  import lcg_mac_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_chain,
  input  logic [WIDTH-1:0] in_seed,
  input  logic [WIDTH-1:0] in_mult,
  input  logic [WIDTH-1:0] in_incr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  localparam int unsigned ITER = iter_of(WIDTH);
  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] pp0, pp1;
  logic [WIDTH:0]   sum;
  logic             cout;
  logic             unused_adder;

  assign pp0 = a_q[0] ? x_q : '0;
  assign pp1 = a_q[1] ? (x_q << 1) : '0;

  csa3_adder #(
    .WIDTH (WIDTH)
  ) u_csa3_adder (
    .a_i    (acc_q),
    .b_i    (pp0),
    .c_i    (pp1),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // Result is modulo 2^WIDTH; the top sum bit and carry out are dropped
  assign unused_adder = ^{cout, sum[WIDTH]};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    x_d       = x_q;
    a_d       = a_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = in_chain ? last_q : in_seed;
          a_d     = in_mult;
          acc_d   = in_incr;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        busy  = 1'b1;
        acc_d = sum[WIDTH-1:0];
        x_d   = x_q << 2;
        a_d   = a_q >> 2;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(ITER - 1)) begin
          last_d  = sum[WIDTH-1:0];
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_result = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      x_q     <= '0;
      a_q     <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      a_q     <= a_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lcg_mac_sequencer.sv
// Self-checking bench for lcg_mac_sequencer against a phase-level arithmetic reference model.
`timescale 1ns/1ps
module tb_lcg_mac_sequencer;

  localparam int ITER = 32;
  localparam logic [63:0] A_MMIX = 64'd6364136223846793005;
  localparam logic [63:0] C_MMIX = 64'd1442695040888963407;
  localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk, rst;
  logic        in_valid, in_ready, in_chain;
  logic [63:0] in_seed, in_mult, in_incr;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  lcg_mac_sequencer #(
    .WIDTH (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_chain   (in_chain),
    .in_seed    (in_seed),
    .in_mult    (in_mult),
    .in_incr    (in_incr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: 0 idle, 1 computing, 2 holding result
  int          m_phase = 0;
  int          m_left  = 0;
  logic [63:0] m_exp   = '0;
  logic [63:0] m_last  = '0;
  int          cyc     = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_phase <= 0;
      m_last  <= '0;
      m_exp   <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_exp   <= in_mult * (in_chain ? m_last : in_seed) + in_incr;
          m_left  <= ITER;
          m_phase <= 1;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_phase <= 2;
            m_last  <= m_exp;
          end
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, m_phase == 0});
      chk("busy", {63'd0, busy}, {63'd0, m_phase == 1});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_phase == 2});
      if (m_phase == 2) chk("out_result", out_result, m_exp);
    end
  end

  logic [63:0] drv_last = '0;

  task automatic run_req(input logic [63:0] seed, input logic [63:0] mult,
                         input logic [63:0] incr, input logic chain, input int stall,
                         output logic [63:0] res, output int lat);
    int guard;
    in_valid  = 1'b1;
    in_seed   = seed;
    in_mult   = mult;
    in_incr   = incr;
    in_chain  = chain;
    out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      $display("FAIL accept_timeout: in_ready never rose");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
    end
    @(negedge clk);
    // Scramble inputs after the accepting edge; the DUT must ignore them
    in_valid = 1'b0;
    in_seed  = {$urandom, $urandom};
    in_mult  = {$urandom, $urandom};
    in_incr  = {$urandom, $urandom};
    in_chain = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = out_result;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_result", out_result, res);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic step(input string name, input logic [63:0] seed, input logic [63:0] mult,
                      input logic [63:0] incr, input logic chain, input int stall,
                      output logic [63:0] res);
    logic [63:0] exp;
    int lat;
    exp = mult * (chain ? drv_last : seed) + incr;
    run_req(seed, mult, incr, chain, stall, res, lat);
    chk(name, res, exp);
    chk("latency", 64'(lat), 64'(ITER));
    drv_last = exp;
  endtask

  logic [63:0] r;
  int          lat0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_chain = 1'b0; out_ready = 1'b0;
    in_seed = '0; in_mult = '0; in_incr = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_out_result", out_result, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    step("identity", 64'd0, A_MMIX, C_MMIX, 1'b0, 0, r);
    chk("identity_literal", r, 64'd1442695040888963407);
    step("unit_seed", 64'd1, A_MMIX, C_MMIX, 1'b0, 0, r);
    chk("unit_seed_literal", r, 64'd7806831264735756412);
    step("chain", 64'd0, A_MMIX, C_MMIX, 1'b1, 0, r);
    chk("chain_model", r, A_MMIX * 64'd7806831264735756412 + C_MMIX);
    step("wrap0", 64'd1, ALL1, 64'd1, 1'b0, 0, r);
    chk("wrap0_literal", r, 64'd0);
    step("wrap1", ALL1, ALL1, 64'd0, 1'b0, 0, r);
    chk("wrap1_literal", r, 64'd1);

    // Backpressure: five stalled cycles in DONE with spurious requests
    step("backpressure", 64'd12345, A_MMIX, C_MMIX, 1'b0, 5, r);
    chk("bp_idle_after", {63'd0, in_ready}, 64'd1);

    // Reset during the computation
    in_valid = 1'b1; in_seed = 64'd999; in_mult = A_MMIX; in_incr = C_MMIX; in_chain = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    drv_last = '0;
    step("chain_after_reset", 64'd77, A_MMIX, C_MMIX, 1'b1, 0, r);
    chk("chain_after_reset_literal", r, C_MMIX);

    for (int i = 0; i < 1000; i++) begin
      logic [63:0] s, a, c;
      s = {$urandom, $urandom};
      a = {$urandom, $urandom};
      c = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) a = ALL1;
      if ($urandom_range(0, 15) == 0) s = ALL1;
      step("random", s, a, c, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 3), r);
    end

    lat0 = 0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcg_mac_sequencer.md
# lcg_mac_sequencer

Multi-cycle sequencer that computes one linear-congruential step, x_next = (A·x + C) mod 2^64, using a single three-operand carry-save adder as its only arithmetic resource. Each cycle it feeds the adder the running accumulator plus two shifted partial products (radix-4 shift-add), so a 64-bit step completes in 32 iterations. It sits between the LCG control/seed logic and the adder datapath, owning all operand selection, iteration counting and the request/response handshake.

## Interface
- WIDTH, 64: operand/result width; must be even.
- ITER, WIDTH/2: iteration count, fixed by WIDTH (localparam).
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  sequencer can accept a request.
- in_chain  in  1  1: use last result as x; 0: use in_seed.
- in_seed  in  WIDTH  x operand when in_chain=0.
- in_mult  in  WIDTH  multiplier A.
- in_incr  in  WIDTH  increment C.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  x_next.
- busy  out  1  high in CALC.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE; acc, x_reg, a_reg, cnt, last_result all cleared.
- IDLE: in_ready=1. On in_valid: x_reg ← (in_chain ? last_result : in_seed); a_reg ← in_mult; acc ← in_incr; cnt ← 0; go to CALC.
- CALC: adder operands are acc, pp0 = a_reg[0] ? x_reg : 0, pp1 = a_reg[1] ? (x_reg<<1) : 0, and Cin = 0. Each edge: acc ← adder sum[WIDTH-1:0]; x_reg ← x_reg<<2 (truncated); a_reg ← a_reg>>2; cnt ← cnt+1. After the edge with cnt = ITER-1, go to DONE and load last_result ← new acc.
- DONE: out_valid=1 and out_result=acc, both stable until the handshake. On out_ready go to IDLE. Results are accepted in DONE and requests in IDLE only; there is no same-cycle overlap.
- Arithmetic is modulo 2^WIDTH. Adder sum bit WIDTH and Cout are discarded. Shifted-out x bits are dropped.
- There is no early exit. Latency is fixed even when the remaining a_reg bits are zero.
- Chain after reset: last_result = 0, so the step result is C.
- Reset in any state takes effect at the next edge: returns to IDLE, any in-flight result is lost, and last_result is cleared.
- out_result equals acc in all states. It is only meaningful while out_valid=1.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, out_result=0.
- Request accepted at edge k (in_valid & in_ready). busy is high from after edge k until after edge k+ITER. out_valid rises after edge k+ITER (32 cycles for WIDTH=64).
- Result held indefinitely under out_ready=0. The next request can be accepted no earlier than the edge after the output handshake.
- The adder path (CSA plus final carry-propagate) is combinational within one cycle. No registers are inside the adder.
- in_* are sampled only at the accepting edge. Changes to them at other times are ignored.

## Structure
- Shared package: state enum {IDLE, CALC, DONE}, WIDTH default, ITER derivation, and the MMIX constants used by benches (A = 6364136223846793005, C = 1442695040888963407).
- One sub-module: csa3_adder (three WIDTH-bit operands plus Cin, giving a WIDTH+1-bit sum and a carry out). It is instantiated once and is purely combinational.
- FSM, counter and operand muxes stay in the top module.

## Test plan
- Identity: seed=0, A=MMIX A, C=MMIX C, chain=0 → out_result = 1442695040888963407, out_valid 32 cycles after accept.
- Unit seed: seed=1, MMIX A/C → 7806831264735756412. A second request with chain=1 must match the reference model A·7806831264735756412 + C mod 2^64.
- Wrap: seed=1, A=2^64−1, C=1 → 0. Then seed=2^64−1, A=2^64−1, C=0 → 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and out_result stable, in_ready=0, and a new in_valid is ignored. Accept on cycle 6, then IDLE.
- Reset mid-CALC: assert rst at iteration 10 → next cycle IDLE with out_valid=0 and busy=0. Then chain=1 with MMIX A/C → result = C.
- Random: 1000 random seed/A/C with random out_ready stalls → every result matches the reference model, and latency is always 32.
